lenet_frame_buffer: RTL and testbench



---
 rtl/lenet_frame_buffer.sv | 141 ++++++++++++++
 tb/tb_lenet_frame_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_frame_buffer.sv
// Double-buffered padded-frame store: captures core pixels into one bank while the
// other bank streams out in raster order over valid/ready.
module lenet_frame_buffer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              frame_done,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_dropped,
    output logic [7:0]        drop_count,
    output logic              busy
);
    localparam int            DEPTH   = IMG_W * IMG_H;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN}       ctrl_t;
    typedef enum logic {R_IDLE, R_STREAM} rd_t;

    ctrl_t r_ctrl, w_ctrl_nxt;
    rd_t   r_rd,   w_rd_nxt;

    logic [DATA_W-1:0] r_bank0 [DEPTH];
    logic [DATA_W-1:0] r_bank1 [DEPTH];

    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_wb;
    logic              r_issuing;
    logic              r_qv;
    logic              r_q_last;
    logic [DATA_W-1:0] r_q;

    logic w_run, w_load_out, w_hs, w_last_hs, w_fd, w_accept, w_drop, w_ren, w_wr_ok;

    always_comb begin
        w_run      = (r_ctrl == RUN);
        w_load_out = !out_valid || out_ready;
        w_hs       = out_valid && out_ready;
        w_last_hs  = w_hs && out_last;
        w_fd       = w_run && frame_done;
        // A frame completing on the final handshake takes over the freed read bank
        w_accept   = w_fd && ((r_rd == R_IDLE) || w_last_hs);
        w_drop     = w_fd && !w_accept;
        w_ren      = r_issuing && (!r_qv || w_load_out);
        w_wr_ok    = w_run && wr_en && ({1'b0, wr_addr} < DEPTH_X);
        busy       = (r_ctrl == CLEAR);
    end

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        w_rd_nxt   = r_rd;
        if (r_ctrl == CLEAR && r_clr_addr == LAST_A) begin
            w_ctrl_nxt = RUN;
        end
        if (w_accept) begin
            w_rd_nxt = R_STREAM;
        end else if (w_last_hs) begin
            w_rd_nxt = R_IDLE;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_ctrl        <= CLEAR;
            r_rd          <= R_IDLE;
            r_clr_addr    <= '0;
            r_raddr       <= '0;
            r_wb          <= 1'b0;
            r_issuing     <= 1'b0;
            r_qv          <= 1'b0;
            r_q_last      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            frame_dropped <= 1'b0;
            drop_count    <= '0;
        end else begin
            r_ctrl <= w_ctrl_nxt;
            r_rd   <= w_rd_nxt;
            if (r_ctrl == CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            if (w_accept) begin
                r_wb      <= ~r_wb;
                r_raddr   <= '0;
                r_issuing <= 1'b1;
            end else if (w_ren) begin
                r_raddr <= r_raddr + 1'b1;
                if (r_raddr == LAST_A) begin
                    r_issuing <= 1'b0;
                end
            end
            // Read-data stage refills whenever its pixel moves into the output stage
            if (w_ren) begin
                r_qv     <= 1'b1;
                r_q_last <= (r_raddr == LAST_A);
            end else if (w_load_out) begin
                r_qv <= 1'b0;
            end
            if (w_load_out) begin
                out_valid <= r_qv;
                out_last  <= r_qv & r_q_last;
                if (r_qv) begin
                    out_data <= r_q;
                end
            end
            frame_dropped <= w_drop;
            if (w_drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (r_ctrl == CLEAR) begin
            r_bank0[r_clr_addr] <= '0;
            r_bank1[r_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            if (r_wb) begin
                r_bank1[wr_addr] <= wr_data;
            end else begin
                r_bank0[wr_addr] <= wr_data;
            end
        end
        if (w_ren) begin
            r_q <= r_wb ? r_bank0[r_raddr] : r_bank1[r_raddr];
        end
    end

endmodule

// File: tb/tb_lenet_frame_buffer.sv
// Randomized bench for lenet_frame_buffer: a bank/queue reference model scores every
// beat, busy, drop pulse and drop count, plus directed latency and boundary checks.
module tb_lenet_frame_buffer;
    localparam int DEPTH = 1024;

    logic       clk25      = 1'b0;
    logic       rst        = 1'b1;
    logic       wr_en      = 1'b0;
    logic [9:0] wr_addr    = '0;
    logic [7:0] wr_data    = '0;
    logic       frame_done = 1'b0;
    logic       out_ready  = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_dropped;
    logic [7:0] drop_count;
    logic       busy;

    lenet_frame_buffer #(.IMG_W(32), .IMG_H(32), .DATA_W(8), .ADDR_W(10)) dut (
        .clk25(clk25), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .frame_dropped(frame_dropped),
        .drop_count(drop_count), .busy(busy)
    );

    always #20 clk25 = ~clk25;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: bank contents, pending output pixels {last,data}, clear countdown
    logic [7:0] m_bank [2][DEPTH];
    int         m_wb    = 0;
    logic [8:0] m_q[$];
    int         m_clr   = DEPTH;
    bit         m_drop  = 1'b0;
    int         m_drops = 0;
    int         m_beats = 0;
    bit         p_stall = 1'b0;
    logic [7:0] p_data;
    logic       p_last;

    always @(negedge clk25) begin
        logic [8:0] e;
        if (rst) begin
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 1);
            m_q.delete();
            m_wb = 0; m_clr = DEPTH; m_drop = 1'b0; m_drops = 0; p_stall = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < DEPTH; i++) m_bank[b][i] = 8'd0;
        end else begin
            check("busy", busy, (m_clr > 0));
            check("dropped", frame_dropped, m_drop);
            check("drop_count", drop_count, m_drops);
            if (p_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, p_data);
                check("hold_last", out_last, p_last);
            end
            if (out_valid && out_ready) begin
                if (m_q.size() == 0) begin
                    check("extra_beat", out_valid, 0);
                end else begin
                    e = m_q.pop_front();
                    check("beat_data", out_data, e[7:0]);
                    check("beat_last", out_last, e[8]);
                    m_beats++;
                end
            end
            p_stall = out_valid && !out_ready;
            p_data  = out_data;
            p_last  = out_last;
            m_drop  = 1'b0;
            if (m_clr > 0) begin
                m_clr--;
            end else begin
                if (wr_en && wr_addr < DEPTH) m_bank[m_wb][wr_addr] = wr_data;
                if (frame_done) begin
                    if (m_q.size() == 0) begin
                        for (int i = 0; i < DEPTH; i++)
                            m_q.push_back({(i == DEPTH - 1), m_bank[m_wb][i]});
                        m_wb ^= 1;
                    end else begin
                        m_drop = 1'b1;
                        if (m_drops < 255) m_drops++;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
    endtask

    task automatic write_interior(input bit rnd);
        for (int r = 2; r <= 29; r++) begin
            for (int c = 2; c <= 29; c++) begin
                wr_en   = 1'b1;
                wr_addr = 10'(r * 32 + c);
                wr_data = rnd ? 8'($urandom) : wr_addr[7:0];
                cyc(1);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while (m_q.size() != 0 && k < budget) begin
            cyc(1);
            k++;
        end
        check(tag, m_q.size(), 0);
        cyc(3);
    endtask

    // Frame_done with ready high: latency to first beat, then one unbroken run
    task automatic stream_with_timing(input string tag);
        int n = 0;
        out_ready = 1'b1;
        pulse_fd();
        check({tag, "_lat0"}, out_valid, 0);
        cyc(1);
        check({tag, "_lat1"}, out_valid, 0);
        cyc(1);
        check({tag, "_lat2"}, out_valid, 1);
        while (out_valid && n < 2000) begin
            n++;
            cyc(1);
        end
        check({tag, "_runlen"}, n, DEPTH);
    endtask

    initial begin
        int k;
        int base;

        rst = 1'b1;
        cyc(5);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_last", out_last, 0);
        check("reset_dropped", frame_dropped, 0);
        check("reset_drop_count", drop_count, 0);
        check("reset_busy", busy, 1);
        rst = 1'b0;
        cyc(1023);
        check("busy_last_cycle", busy, 1);
        cyc(1);
        check("busy_released", busy, 0);

        stream_with_timing("zeros");
        wait_drain("zeros_drain", 100);

        write_interior(1'b0);
        stream_with_timing("single");
        wait_drain("single_drain", 100);

        write_interior(1'b1);
        out_ready = 1'b0;
        pulse_fd();
        base = $urandom_range(0, 2);
        k = 0;
        while (m_q.size() != 0 && k < 5000) begin
            out_ready = ((k + base) % 3 != 0) ? 1'b1 : 1'b0;
            cyc(1);
            k++;
        end
        out_ready = 1'b1;
        wait_drain("bp_drain", 100);

        out_ready = 1'b0;
        write_interior(1'b1);
        pulse_fd();
        write_interior(1'b1);
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        check("ovf_pulse", frame_dropped, 1);
        check("ovf_count", drop_count, 1);
        cyc(1);
        check("ovf_pulse_end", frame_dropped, 0);
        cyc($urandom_range(1, 20));
        out_ready = 1'b1;
        wait_drain("ovf_drain", 3000);

        out_ready = 1'b0;
        pulse_fd();
        repeat (300) begin
            pulse_fd();
            cyc(1);
        end
        check("sat_count", drop_count, 255);
        out_ready = 1'b1;
        wait_drain("sat_drain", 3000);

        write_interior(1'b1);
        out_ready = 1'b1;
        pulse_fd();
        write_interior(1'b1);
        k = 0;
        while (!(out_valid && out_last) && k < 3000) begin
            cyc(1);
            k++;
        end
        check("coinc_last_seen", out_valid && out_last, 1);
        frame_done = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 10'($urandom_range(2, 29) * 32 + $urandom_range(2, 29));
        wr_data    = 8'($urandom);
        cyc(1);
        frame_done = 1'b0;
        wr_en      = 1'b0;
        check("coinc_no_drop", frame_dropped, 0);
        check("coinc_lat0", out_valid, 0);
        cyc(1);
        check("coinc_lat1", out_valid, 0);
        cyc(1);
        check("coinc_lat2", out_valid, 1);
        wait_drain("coinc_drain", 3000);

        write_interior(1'b1);
        out_ready = 1'b1;
        base = m_beats;
        pulse_fd();
        k = 0;
        while (m_beats < base + 500 && k < 3000) begin
            cyc(1);
            k++;
        end
        check("midrst_reached", (m_beats >= base + 500), 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 1);
        cyc(2);
        rst = 1'b0;
        cyc(1024);
        check("midrst_busy_released", busy, 0);
        stream_with_timing("midrst_zeros");
        wait_drain("midrst_drain", 100);

        check("final_queue", m_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
